spi_slave: RTL and testbench

//  APB-programmable SPI slave (target) for the same SPI bus the spi_master drives; supports all four CPOL/CPHA modes.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: APB register map, CTRL/STATUS bit positions and
// the slave FSM state encoding.
package spi_pkg;

  // APB byte addresses
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_RXDATA = 8'h08;
  localparam logic [7:0] ADDR_TXDATA = 8'h0C;

  // CTRL bits
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CPOL   = 1;
  localparam int CTRL_CPHA   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_W      = 4;

  // STATUS bits
  localparam int ST_BUSY     = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_OVR      = 3;
  localparam int ST_UDR      = 4;
  localparam int ST_ABORT    = 5;
  localparam int STATUS_W    = 6;

  // FSM encoding
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  // The edge on which SCLK leaves its idle level (cpol) is the leading edge.
  function automatic logic leading_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous SPI pin plus rise/fall pulse detection.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   d_i        : asynchronous input pin
//   q_o        : synchronised level (SYNC_STAGES flops)
//   rise_o     : one-cycle pulse on synchronised 0->1
//   fall_o     : one-cycle pulse on synchronised 1->0
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// APB-programmable SPI slave supporting all four CPOL/CPHA modes.
// SPI pins are oversampled in the clk domain; 8-bit MSB-first frames are
// deserialised into RXDATA while TXDATA is serialised onto MISO.
// Ports:
//   clk, rst_n                       : system clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata : APB request
//   prdata, pready                   : APB response (zero wait states)
//   spi_sclk, spi_cs_n, spi_mosi     : asynchronous SPI inputs
//   spi_miso, spi_miso_oe            : SPI data out and pad enable
//   irq                              : level interrupt
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  localparam int CNT_W = $clog2(DATA_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(spi_sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // cs_n idles high so that reset never produces a false falling edge
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(spi_mosi),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{pwdata[31:DATA_W], sclk_s, cs_s, mosi_rise, mosi_fall};

  logic [0:0]        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_empty_q, tx_empty_d;
  logic              ovr_q, ovr_d;
  logic              udr_q, udr_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
  logic [DATA_W-1:0] txsr_q, txsr_d;
  logic [DATA_W-1:0] rxsr_q, rxsr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              irq_q, irq_d;
  logic [31:0]       prdata_q, prdata_d;

  logic                busy;
  logic [STATUS_W-1:0] status_w;
  logic                lead, trail, sample_edge, shift_edge;
  logic                apb_wr, apb_rd, rd_rx;
  logic [DATA_W-1:0]   tx_next, rx_word;

  assign busy     = (state_q == S_ACTIVE);
  assign status_w = {abort_q, udr_q, ovr_q, tx_empty_q, rx_valid_q, busy};

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    rx_valid_d  = rx_valid_q;
    tx_empty_d  = tx_empty_q;
    ovr_d       = ovr_q;
    udr_d       = udr_q;
    abort_d     = abort_q;
    rx_data_d   = rx_data_q;
    tx_hold_d   = tx_hold_q;
    txsr_d      = txsr_q;
    rxsr_d      = rxsr_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    prdata_d    = prdata_q;

    lead        = leading_edge(ctrl_q[CTRL_CPOL], sclk_rise, sclk_fall);
    trail       = leading_edge(ctrl_q[CTRL_CPOL], sclk_fall, sclk_rise);
    sample_edge = ctrl_q[CTRL_CPHA] ? trail : lead;
    shift_edge  = ctrl_q[CTRL_CPHA] ? lead  : trail;

    apb_wr  = psel & penable & pwrite;
    apb_rd  = psel & penable & ~pwrite;
    rd_rx   = apb_rd && (paddr == ADDR_RXDATA);

    // Word handed to txsr at the start of every frame; all-ones on underrun.
    tx_next = tx_empty_q ? {DATA_W{1'b1}} : tx_hold_q;
    rx_word = {rxsr_q[DATA_W-2:0], mosi_s};

    // APB clears first so that a flag raised by the SPI side in the same
    // cycle wins over the software clear.
    if (apb_wr && paddr == ADDR_CTRL) ctrl_d = pwdata[CTRL_W-1:0];
    if (apb_wr && paddr == ADDR_STATUS) begin
      if (pwdata[ST_OVR])   ovr_d   = 1'b0;
      if (pwdata[ST_UDR])   udr_d   = 1'b0;
      if (pwdata[ST_ABORT]) abort_d = 1'b0;
    end
    if (rd_rx) rx_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        miso_oe_d = 1'b0;
        if (cs_fall && ctrl_q[CTRL_EN]) begin
          state_d   = S_ACTIVE;
          bit_cnt_d = '0;
          miso_oe_d = 1'b1;
          if (tx_empty_q) udr_d = 1'b1;
          else            tx_empty_d = 1'b1;
          // MSB goes out now; with CPHA=0 it is already consumed, with
          // CPHA=1 the first leading edge re-drives it and then shifts.
          miso_d = tx_next[DATA_W-1];
          txsr_d = ctrl_q[CTRL_CPHA] ? tx_next : (tx_next << 1);
        end
      end
      default: begin
        if (cs_rise || !ctrl_q[CTRL_EN]) begin
          if (bit_cnt_q != '0) abort_d = 1'b1;
          state_d   = S_IDLE;
          miso_oe_d = 1'b0;
          bit_cnt_d = '0;
        end else begin
          if (shift_edge) begin
            miso_d = txsr_q[DATA_W-1];
            txsr_d = txsr_q << 1;
          end
          if (sample_edge) begin
            rxsr_d = rx_word;
            if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
              rx_data_d  = rx_word;
              if (rx_valid_q && !rd_rx) ovr_d = 1'b1;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              // Back-to-back frame under the same CS: reload the full word;
              // the next shift edge drives its MSB.
              if (tx_empty_q) udr_d = 1'b1;
              else            tx_empty_d = 1'b1;
              txsr_d = tx_next;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
      end
    endcase

    // A TXDATA write coinciding with a reload lands after it.
    if (apb_wr && paddr == ADDR_TXDATA) begin
      tx_hold_d  = pwdata[DATA_W-1:0];
      tx_empty_d = 1'b0;
    end

    if (psel && !penable) begin
      case (paddr)
        ADDR_CTRL:   prdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
        ADDR_STATUS: prdata_d = {{(32-STATUS_W){1'b0}}, status_w};
        ADDR_RXDATA: prdata_d = {{(32-DATA_W){1'b0}}, rx_data_q};
        default:     prdata_d = 32'd0;
      endcase
    end

    irq_d = ctrl_q[CTRL_IRQ_EN] & (rx_valid_q | ovr_q | udr_q | abort_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      rx_valid_q <= 1'b0;
      tx_empty_q <= 1'b1;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      abort_q    <= 1'b0;
      rx_data_q  <= '0;
      tx_hold_q  <= '0;
      txsr_q     <= {DATA_W{1'b1}};
      rxsr_q     <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      irq_q      <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      rx_valid_q <= rx_valid_d;
      tx_empty_q <= tx_empty_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
      abort_q    <= abort_d;
      rx_data_q  <= rx_data_d;
      tx_hold_q  <= tx_hold_d;
      txsr_q     <= txsr_d;
      rxsr_q     <= rxsr_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      irq_q      <= irq_d;
      prdata_q   <= prdata_d;
    end
  end

  assign prdata      = prdata_q;
  assign pready      = 1'b1;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: acts as SPI master and APB host, keeps a
// register-level model of the slave and checks the DUT against it.
module tb_spi_slave;

  localparam int H = 80;  // SCLK half period (8 clk cycles)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready;
  logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, irq;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic       m_en, m_irq_en, m_cpol, m_cpha, m_busy;
  logic       m_rx_valid, m_tx_empty, m_ovr, m_udr, m_abort;
  logic [7:0] m_rxdata, m_tx_hold, m_tx_byte;
  int         m_bitcnt;

  logic [31:0] d;
  logic [7:0]  mi;

  spi_slave dut (
    .clk(clk), .rst_n(rst_n),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {26'd0, m_abort, m_udr, m_ovr, m_tx_empty, m_rx_valid, m_busy};
  endfunction

  function automatic logic m_irq();
    return m_irq_en & (m_rx_valid | m_ovr | m_udr | m_abort);
  endfunction

  task automatic m_reset();
    m_en = 0; m_irq_en = 0; m_cpol = 0; m_cpha = 0; m_busy = 0;
    m_rx_valid = 0; m_tx_empty = 1; m_ovr = 0; m_udr = 0; m_abort = 0;
    m_rxdata = 0; m_tx_hold = 0; m_tx_byte = 8'hFF; m_bitcnt = 0;
  endtask

  // Word the slave will shift out for the frame now starting.
  task automatic m_load_tx();
    if (m_tx_empty) begin m_tx_byte = 8'hFF; m_udr = 1; end
    else begin m_tx_byte = m_tx_hold; m_tx_empty = 1; end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = v;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
    case (a)
      8'h00: begin m_en = v[0]; m_cpol = v[1]; m_cpha = v[2]; m_irq_en = v[3]; end
      8'h04: begin if (v[3]) m_ovr = 0; if (v[4]) m_udr = 0; if (v[5]) m_abort = 0; end
      8'h0C: begin m_tx_hold = v[7:0]; m_tx_empty = 0; end
      default: ;
    endcase
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1;
    penable = 1;
    v = prdata;
    @(posedge clk); #1;
    psel = 0; penable = 0;
    if (a == 8'h08) m_rx_valid = 0;
  endtask

  task automatic set_mode(input logic cpol, input logic cpha);
    apb_write(8'h00, {28'd0, 1'b1, cpha, cpol, 1'b1});
    spi_sclk = cpol;
    #(H);
  endtask

  task automatic cs_low();
    spi_cs_n = 0;
    if (m_en) begin m_busy = 1; m_bitcnt = 0; m_load_tx(); end
    #(H);
  endtask

  task automatic cs_high();
    #(H);
    spi_cs_n = 1;
    if (m_busy && m_bitcnt != 0) m_abort = 1;
    m_busy = 0;
    #(H);
    chk("miso_oe_after_cs", 32'(spi_miso_oe), 32'd0);
  endtask

  // Clock nbits of a frame; a full frame is checked against the model.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] got);
    logic [7:0] exp;
    exp = m_tx_byte;
    got = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      if (!m_cpha) begin
        spi_mosi = mo[7-i]; #(H);
        spi_sclk = ~m_cpol; got[7-i] = spi_miso; #(H);
        spi_sclk = m_cpol;
      end else begin
        spi_sclk = ~m_cpol; spi_mosi = mo[7-i]; #(H);
        spi_sclk = m_cpol; got[7-i] = spi_miso; #(H);
      end
      if (i == 0) chk("miso_oe_in_frame", 32'(spi_miso_oe), 32'd1);
    end
    m_bitcnt = (m_bitcnt + nbits) % 8;
    if (nbits == 8) begin
      chk("miso_frame", 32'(got), 32'(exp));
      if (m_rx_valid) m_ovr = 1;
      m_rx_valid = 1;
      m_rxdata = mo;
      m_load_tx();
    end
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    chk({tag, "_irq"}, 32'(irq), 32'(m_irq()));
    apb_read(8'h04, v);
    chk({tag, "_status"}, v, m_status());
    apb_read(8'h08, v);
    chk({tag, "_rxdata"}, v, 32'(m_rxdata));
  endtask

  initial begin
    m_reset();
    #23 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pready", 32'(pready), 32'd1);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    apb_read(8'h04, d);
    chk("rst_status", d, 32'h04);
    chk("rst_status_model", d, m_status());
    apb_read(8'h20, d);
    chk("unmapped_read", d, 32'd0);

    // Mode 0
    set_mode(0, 0);
    apb_write(8'h0C, 32'hA5);
    cs_low(); xfer(8'h3C, 8, mi); cs_high();
    chk("m0_miso_lit", 32'(mi), 32'hA5);
    chk("m0_irq_lit", 32'(irq), 32'd1);
    apb_read(8'h04, d);
    chk("m0_rx_valid_lit", 32'(d[1]), 32'd1);
    apb_read(8'h08, d);
    chk("m0_rxdata_lit", d, 32'h3C);
    apb_read(8'h04, d);
    chk("m0_status_after_read", d, m_status());
    apb_write(8'h04, 32'h38);

    // Modes 3, 1, 2
    for (int m = 0; m < 3; m++) begin
      logic pol, pha;
      pol = (m == 0 || m == 2);
      pha = (m == 0 || m == 1);
      set_mode(pol, pha);
      apb_write(8'h0C, 32'h81);
      cs_low(); xfer(8'h7E, 8, mi); cs_high();
      chk("mode_miso_lit", 32'(mi), 32'h81);
      check_regs("mode");
      chk("mode_rxdata_lit", 32'(m_rxdata), 32'h7E);
      apb_write(8'h04, 32'h38);
    end

    // Overrun, with underrun since TXDATA is never written
    set_mode(0, 0);
    cs_low(); xfer(8'h11, 8, mi); cs_high();
    chk("udr_miso_lit", 32'(mi), 32'hFF);
    cs_low(); xfer(8'h22, 8, mi); cs_high();
    apb_read(8'h04, d);
    chk("ovr_set_lit", 32'(d[3]), 32'd1);
    chk("ovr_status", d, m_status());
    apb_write(8'h04, 32'h08);
    apb_read(8'h04, d);
    chk("ovr_clr_lit", 32'(d[3]), 32'd0);
    chk("udr_kept_lit", 32'(d[4]), 32'd1);
    apb_read(8'h08, d);
    chk("ovr_rxdata_lit", d, 32'h22);
    apb_write(8'h04, 32'h10);
    apb_read(8'h04, d);
    chk("udr_clr_status", d, m_status());

    // Two frames under one CS
    apb_write(8'h0C, 32'h5C);
    cs_low();
    xfer(8'h12, 8, mi);
    chk("b2b_first_miso_lit", 32'(mi), 32'h5C);
    apb_read(8'h04, d);
    chk("b2b_busy_status", d, m_status());
    apb_read(8'h08, d);
    chk("b2b_first_rx_lit", d, 32'h12);
    xfer(8'h34, 8, mi);
    chk("b2b_second_miso_lit", 32'(mi), 32'hFF);
    cs_high();
    check_regs("b2b");
    chk("b2b_second_rx_lit", 32'(m_rxdata), 32'h34);
    apb_write(8'h04, 32'h38);

    // Abort after 3 bits, then a clean frame
    cs_low(); xfer(8'hF0, 3, mi); cs_high();
    apb_read(8'h04, d);
    chk("abort_lit", 32'(d[5]), 32'd1);
    chk("abort_rx_valid_lit", 32'(d[1]), 32'd0);
    chk("abort_status", d, m_status());
    apb_write(8'h04, 32'h38);
    apb_write(8'h0C, 32'h96);
    cs_low(); xfer(8'h5A, 8, mi); cs_high();
    chk("post_abort_miso_lit", 32'(mi), 32'h96);
    check_regs("post_abort");
    chk("post_abort_rx_lit", 32'(m_rxdata), 32'h5A);

    // Reset in the middle of a frame
    apb_write(8'h0C, 32'h3B);
    cs_low(); xfer(8'hAA, 4, mi);
    rst_n = 0;
    #2;
    chk("midrst_miso_oe", 32'(spi_miso_oe), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    m_reset();
    spi_cs_n = 1;
    spi_sclk = 0;
    #(H);
    rst_n = 1;
    #(H);
    apb_read(8'h04, d);
    chk("midrst_status_lit", d, 32'h04);
    set_mode(0, 0);
    cs_low(); xfer(8'hC3, 8, mi); cs_high();
    check_regs("post_rst");
    chk("post_rst_rx_lit", 32'(m_rxdata), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
